load_unit: RTL and testbench

Load functional unit downstream of the load reservation station. It accepts one issued load at a time (effective address, subtype, ROB tag) and performs a single-word read on the data-memory port. It extracts and sign- or zero-extends the addressed byte, halfword or word, then broadcasts the result on its CDB slot under an arbiter request/grant handshake. While it is busy it back-pressures the station.

---
 rtl/load_unit.sv | 148 ++++++++++++++
 tb/tb_load_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// Load functional unit: issues one word read per accepted load, extracts/extends the addressed lane, broadcasts on the CDB.
// Optional macro LOAD_MISALIGN_CHECK_EN adds cdbException and short-circuits misaligned LH/LHU/LW to an exception broadcast.
module load_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        loadEnable,
  input  logic [31:0] data_in,
  input  logic [2:0]  type_in,
  input  logic [5:0]  robNum_in,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        cdb_req,
  input  logic        cdb_grant,
  output logic        cdbIscast,
  output logic [31:0] cdbData,
  output logic [5:0]  cdbRobNum
`ifdef LOAD_MISALIGN_CHECK_EN
  ,
  output logic        cdbException
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    WAIT  = 2'b10,
    BCAST = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  type_q, type_d;
  logic [5:0]  rob_q, rob_d;
  logic [31:0] data_q, data_d;
  logic        accept;
  logic        mem_done;
  logic        misaligned;
`ifdef LOAD_MISALIGN_CHECK_EN
  logic        exc_q, exc_d;
`endif

  // Subtypes 011/110/111 fall through to the word path.
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  lane,
                                          input logic [2:0]  typ);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (typ)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'b0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'b0, h};
      default: extract = w;
    endcase
  endfunction

  assign accept   = (state_q == IDLE) && loadEnable;
  assign mem_done = ((state_q == REQ) || (state_q == WAIT)) && mem_ack;

`ifdef LOAD_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (type_in)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = data_in[0];
      default:        misaligned = (data_in[1:0] != 2'b00);
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (loadEnable) state_d = misaligned ? BCAST : REQ;
      REQ:     state_d = mem_ack ? BCAST : WAIT;
      WAIT:    if (mem_ack) state_d = BCAST;
      BCAST:   if (cdb_grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    lane_d = lane_q;
    type_d = type_q;
    rob_d  = rob_q;
    data_d = data_q;
`ifdef LOAD_MISALIGN_CHECK_EN
    exc_d  = exc_q;
`endif
    if (accept) begin
      addr_d = {data_in[31:2], 2'b00};
      lane_d = data_in[1:0];
      type_d = type_in;
      rob_d  = robNum_in;
`ifdef LOAD_MISALIGN_CHECK_EN
      exc_d  = misaligned;
      if (misaligned) data_d = 32'b0;
`endif
    end else if (mem_done) begin
      data_d = extract(mem_rdata, lane_q, type_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'b0;
      lane_q  <= 2'b0;
      type_q  <= 3'b0;
      rob_q   <= 6'b0;
      data_q  <= 32'b0;
`ifdef LOAD_MISALIGN_CHECK_EN
      exc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      type_q  <= type_d;
      rob_q   <= rob_d;
      data_q  <= data_d;
`ifdef LOAD_MISALIGN_CHECK_EN
      exc_q   <= exc_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_req   = (state_q == REQ) || (state_q == WAIT);
  assign mem_addr  = addr_q;
  assign cdb_req   = (state_q == BCAST);
  assign cdbIscast = (state_q == BCAST);
  assign cdbData   = data_q;
  assign cdbRobNum = rob_q;
`ifdef LOAD_MISALIGN_CHECK_EN
  assign cdbException = exc_q;
`endif

endmodule

// File: tb/tb_load_unit.sv
// Directed and randomized checks of load_unit against a lane-arithmetic reference model.
module tb_load_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        loadEnable;
  logic [31:0] data_in;
  logic [2:0]  type_in;
  logic [5:0]  robNum_in;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        cdb_req;
  logic        cdb_grant;
  logic        cdbIscast;
  logic [31:0] cdbData;
  logic [5:0]  cdbRobNum;
`ifdef LOAD_MISALIGN_CHECK_EN
  logic        cdbException;
`endif

  int vectors = 0;
  int miscompares = 0;

  load_unit dut (
    .clock(clock), .reset(reset), .loadEnable(loadEnable), .data_in(data_in),
    .type_in(type_in), .robNum_in(robNum_in), .busy(busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdbIscast(cdbIscast),
    .cdbData(cdbData), .cdbRobNum(cdbRobNum)
`ifdef LOAD_MISALIGN_CHECK_EN
    , .cdbException(cdbException)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Reference: select the lane by shifting, reduce modulo lane size, subtract the range for signed types.
  function automatic logic [31:0] model(input logic [31:0] addr, input logic [2:0] typ,
                                        input logic [31:0] rdata);
    longint r, v;
    int a;
    r = longint'({32'b0, rdata});
    a = int'({30'b0, addr[1:0]});
    case (typ)
      3'd0, 3'd4: begin
        v = (r >> (8 * a)) % 256;
        if (typ == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (r >> (16 * (a / 2))) % 65536;
        if (typ == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = r;
    endcase
    return v[31:0];
  endfunction

  function automatic bit is_misaligned(input logic [31:0] addr, input logic [2:0] typ);
    if (typ == 3'd0 || typ == 3'd4) return 1'b0;
    if (typ == 3'd1 || typ == 3'd5) return addr[0];
    return addr[1:0] != 2'b00;
  endfunction

  // Entered just after a rising edge with the unit idle; returns just after the grant edge.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] typ, input logic [5:0] tag,
                          input logic [31:0] rdata, input int waits, input int denies,
                          input bit pulse_le);
    logic [31:0] exp_d;
    bit mis;
    mis = 1'b0;
`ifdef LOAD_MISALIGN_CHECK_EN
    mis = is_misaligned(addr, typ);
`endif
    exp_d = mis ? 32'b0 : model(addr, typ, rdata);
    loadEnable = 1'b1; data_in = addr; type_in = typ; robNum_in = tag;
    @(negedge clock);
    chk1("idle_before_accept", busy, 1'b0);
    @(posedge clock); #1;
    loadEnable = 1'b0; data_in = $urandom; type_in = 3'($urandom); robNum_in = 6'($urandom);
    if (!mis) begin
      for (int i = 0; i <= waits; i++) begin
        mem_ack   = (i == waits);
        mem_rdata = (i == waits) ? rdata : $urandom;
        @(negedge clock);
        chk1("busy_mem", busy, 1'b1);
        chk1("mem_req_held", mem_req, 1'b1);
        chk32("mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk1("cdb_req_during_mem", cdb_req, 1'b0);
        @(posedge clock); #1;
      end
    end
    mem_ack = 1'b0;
    for (int i = 0; i <= denies; i++) begin
      cdb_grant = (i == denies);
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      if (pulse_le && i < denies) begin
        loadEnable = 1'b1; data_in = $urandom; robNum_in = ~tag;
      end else begin
        loadEnable = 1'b0;
      end
      @(negedge clock);
      chk1("busy_bcast", busy, 1'b1);
      chk1("mem_req_bcast", mem_req, 1'b0);
      chk1("cdb_req", cdb_req, 1'b1);
      chk1("cdbIscast", cdbIscast, 1'b1);
      chk32("cdbData", cdbData, exp_d);
      chk32("cdbRobNum", 32'(cdbRobNum), 32'(tag));
`ifdef LOAD_MISALIGN_CHECK_EN
      chk1("cdbException", cdbException, mis);
`endif
      @(posedge clock); #1;
    end
    cdb_grant = 1'b0; mem_ack = 1'b0; loadEnable = 1'b0;
    chk1("busy_after_grant", busy, 1'b0);
    chk1("iscast_after_grant", cdbIscast, 1'b0);
    chk32("data_hold_after_grant", cdbData, exp_d);
  endtask

  initial begin
    reset = 1'b1; loadEnable = 1'b0; data_in = '0; type_in = '0; robNum_in = '0;
    mem_ack = 1'b0; mem_rdata = '0; cdb_grant = 1'b0;
    #3;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_cdb_req", cdb_req, 1'b0);
    chk1("rst_iscast", cdbIscast, 1'b0);
    chk32("rst_cdbData", cdbData, 32'h0);
    chk32("rst_cdbRobNum", 32'(cdbRobNum), 32'h0);
`ifdef LOAD_MISALIGN_CHECK_EN
    chk1("rst_exc", cdbException, 1'b0);
`endif
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    // Stray ack and grant while idle.
    mem_ack = 1'b1; cdb_grant = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    mem_ack = 1'b0; cdb_grant = 1'b0;
    @(negedge clock);
    chk1("stray_idle_busy", busy, 1'b0);
    chk1("stray_idle_cdb_req", cdb_req, 1'b0);
    chk32("stray_idle_data", cdbData, 32'h0);
    @(posedge clock); #1;

    run_load(32'h0000_1003, 3'b000, 6'd5, 32'h80FF_FF12, 0, 0, 1'b0);
    run_load(32'h0000_2002, 3'b101, 6'd6, 32'hBEEF_1234, 4, 0, 1'b0);
    run_load(32'h0000_3000, 3'b010, 6'd8, 32'hDEAD_BEEF, 0, 3, 1'b1);
    run_load(32'h0000_0101, 3'b000, 6'd1, 32'h1234_8056, 0, 0, 1'b0);
    run_load(32'h0000_0202, 3'b001, 6'd2, 32'h9ABC_0000, 1, 0, 1'b0);

    // Reset during a memory stall; the late ack must be ignored.
    loadEnable = 1'b1; data_in = 32'h0000_5004; type_in = 3'b010; robNum_in = 6'd9;
    @(posedge clock); #1; loadEnable = 1'b0;
    @(posedge clock); #1;
    chk1("wait_mem_req", mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("async_rst_mem_req", mem_req, 1'b0);
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_cdb_req", cdb_req, 1'b0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clock); #1; mem_ack = 1'b0;
    @(negedge clock);
    chk1("late_ack_busy", busy, 1'b0);
    chk1("late_ack_no_bcast", cdbIscast, 1'b0);
    chk32("late_ack_data", cdbData, 32'h0);
    @(posedge clock); #1;
    run_load(32'h0000_6008, 3'b010, 6'd7, 32'hCAFE_F00D, 0, 0, 1'b0);

`ifdef LOAD_MISALIGN_CHECK_EN
    run_load(32'h0000_4001, 3'b010, 6'd3, 32'h1111_2222, 0, 0, 1'b0);
    run_load(32'h0000_4003, 3'b101, 6'd4, 32'h3333_4444, 2, 1, 1'b0);
`endif

    for (int n = 0; n < 60; n++) begin
      run_load($urandom, 3'($urandom), 6'($urandom), $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
